// File: rtl/acc_pipe_ctrl.sv
// Pipeline control for the accumulator machine: decodes the instruction in ID,
// sequences indirect-fetch, branch and halt stalls, and drives registered enables.
module acc_pipe_ctrl #(
    parameter int unsigned BR_BUBBLES = 1,
    parameter logic [5:0]  CB_DEFAULT = 6'b110000
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_op,
    input  logic        id_ind,
    input  logic        cond_zr,
    input  logic        cond_ng,
    input  logic        resume,
    output logic        if_en,
    output logic        id_flush,
    output logic        pc_load,
    output logic        ex_en,
    output logic        acc_we,
    output logic        mem_we,
    output logic [5:0]  cb,
    output logic        ind_wait,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {StRun, StInd, StBranch, StHalt} state_e;

    localparam logic [4:0] OpStore = 5'h13;
    localparam logic [4:0] OpJmp   = 5'h14;
    localparam logic [4:0] OpJz    = 5'h15;
    localparam logic [4:0] OpJn    = 5'h16;
    localparam logic [4:0] OpHlt   = 5'h17;

    state_e      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        if_en_q, if_en_d;
    logic        id_flush_q, id_flush_d;
    logic        pc_load_q, pc_load_d;
    logic        ex_en_q, ex_en_d;
    logic        acc_we_q, acc_we_d;
    logic        mem_we_q, mem_we_d;
    logic [5:0]  cb_q, cb_d;
    logic        ind_wait_q, ind_wait_d;
    logic        halted_q, halted_d;
    logic [15:0] retired_q, retired_d;

    logic       run_valid, store_hold, go_ind, issue, taken, is_alu;
    logic [4:0] iss_op;

    function automatic logic [5:0] alu_cb(input logic [4:0] op);
        logic [5:0] r;
        unique case (op)
            5'h00: r = 6'b101010;
            5'h01: r = 6'b111111;
            5'h02: r = 6'b111010;
            5'h03: r = 6'b001100;
            5'h04: r = 6'b110000;
            5'h05: r = 6'b001101;
            5'h06: r = 6'b110001;
            5'h07: r = 6'b001111;
            5'h08: r = 6'b110011;
            5'h09: r = 6'b011111;
            5'h0A: r = 6'b110111;
            5'h0B: r = 6'b001110;
            5'h0C: r = 6'b110010;
            5'h0D: r = 6'b000010;
            5'h0E: r = 6'b010011;
            5'h0F: r = 6'b000111;
            5'h10: r = 6'b000000;
            5'h11: r = 6'b010101;
            5'h12: r = 6'b110000;
            default: r = CB_DEFAULT;
        endcase
        return r;
    endfunction

    // Issue decode shared by the next-state and output processes.
    always_comb begin
        run_valid  = (state_q == StRun) && id_valid;
        // A direct STORE right behind a STORE is held so mem_we never pulses twice in a row.
        store_hold = run_valid && !id_ind && (id_op == OpStore) && mem_we_q;
        go_ind     = run_valid && !store_hold && id_ind && (id_op != OpHlt);
        iss_op     = (state_q == StInd) ? op_q : id_op;
        issue      = (state_q == StInd) || (run_valid && !store_hold && !go_ind);
        taken      = issue && ((iss_op == OpJmp) || ((iss_op == OpJz) && cond_zr) ||
                               ((iss_op == OpJn) && cond_ng));
        is_alu     = (iss_op <= 5'h12) || (iss_op >= 5'h18);
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= StRun;
            op_q       <= '0;
            cnt_q      <= '0;
            if_en_q    <= 1'b1;
            id_flush_q <= 1'b0;
            pc_load_q  <= 1'b0;
            ex_en_q    <= 1'b0;
            acc_we_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            cb_q       <= '0;
            ind_wait_q <= 1'b0;
            halted_q   <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            if_en_q    <= if_en_d;
            id_flush_q <= id_flush_d;
            pc_load_q  <= pc_load_d;
            ex_en_q    <= ex_en_d;
            acc_we_q   <= acc_we_d;
            mem_we_q   <= mem_we_d;
            cb_q       <= cb_d;
            ind_wait_q <= ind_wait_d;
            halted_q   <= halted_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun, StInd: begin
                if (go_ind) begin
                    state_d = StInd;
                    op_d    = id_op;
                end else if (taken) begin
                    state_d = StBranch;
                    cnt_d   = 2'(BR_BUBBLES);
                end else if (issue && (iss_op == OpHlt)) begin
                    state_d = StHalt;
                end else begin
                    state_d = StRun;
                end
            end
            StBranch: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) state_d = StRun;
            end
            StHalt: begin
                if (resume) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        if_en_d    = 1'b1;
        id_flush_d = 1'b0;
        pc_load_d  = 1'b0;
        ex_en_d    = 1'b0;
        acc_we_d   = 1'b0;
        mem_we_d   = 1'b0;
        cb_d       = '0;
        ind_wait_d = 1'b0;
        halted_d   = 1'b0;
        retired_d  = retired_q;
        if (issue) begin
            retired_d = retired_q + 16'd1;
            if (is_alu) begin
                ex_en_d  = 1'b1;
                acc_we_d = 1'b1;
                cb_d     = alu_cb(iss_op);
            end else if (iss_op == OpStore) begin
                ex_en_d  = 1'b1;
                mem_we_d = 1'b1;
            end else if (iss_op == OpHlt) begin
                halted_d = 1'b1;
                if_en_d  = 1'b0;
            end else if (taken) begin
                pc_load_d  = 1'b1;
                id_flush_d = 1'b1;
            end
        end
        if (go_ind) begin
            if_en_d    = 1'b0;
            ind_wait_d = 1'b1;
        end
        if (store_hold) if_en_d = 1'b0;
        if (state_q == StBranch) if_en_d = 1'b0;
        if ((state_q == StHalt) && !resume) begin
            halted_d = 1'b1;
            if_en_d  = 1'b0;
        end
    end

    assign if_en    = if_en_q;
    assign id_flush = id_flush_q;
    assign pc_load  = pc_load_q;
    assign ex_en    = ex_en_q;
    assign acc_we   = acc_we_q;
    assign mem_we   = mem_we_q;
    assign cb       = cb_q;
    assign ind_wait = ind_wait_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_acc_pipe_ctrl.sv
// Scoreboard bench for acc_pipe_ctrl: the driver queues hand-computed output vectors,
// a negedge monitor pops and compares them against the registered outputs.
module tb_acc_pipe_ctrl;

    logic        clk1 = 1'b0;
    logic        rst, id_valid, id_ind, cond_zr, cond_ng, resume;
    logic [4:0]  id_op;
    logic        if_en, id_flush, pc_load, ex_en, acc_we, mem_we, ind_wait, halted;
    logic [5:0]  cb;
    logic [15:0] retired;

    typedef struct {
        logic [29:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    acc_pipe_ctrl #(.BR_BUBBLES(2), .CB_DEFAULT(6'b101101)) dut (
        .clk1(clk1), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_ind(id_ind),
        .cond_zr(cond_zr), .cond_ng(cond_ng), .resume(resume), .if_en(if_en),
        .id_flush(id_flush), .pc_load(pc_load), .ex_en(ex_en), .acc_we(acc_we),
        .mem_we(mem_we), .cb(cb), .ind_wait(ind_wait), .halted(halted), .retired(retired)
    );

    always #5 clk1 = ~clk1;

    // Packed as {if_en,id_flush,pc_load,ex_en,acc_we,mem_we,cb,ind_wait,halted,retired}.
    function automatic logic [29:0] ev(input logic ifn, fl, pl, ex, aw, mw,
                                        input logic [5:0] c, input logic iw, h,
                                        input logic [15:0] r);
        return {ifn, fl, pl, ex, aw, mw, c, iw, h, r};
    endfunction

    always @(negedge clk1) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [29:0] act;
            e   = sb.pop_front();
            act = {if_en, id_flush, pc_load, ex_en, acc_we, mem_we, cb, ind_wait, halted,
                   retired};
            n_cmp++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", e.nm, act, e.v);
            end
        end
    end

    task automatic cyc(input logic v, input logic [4:0] op, input logic ind, zr, ng, res, rs,
                       input bit chk, input logic [29:0] e, input string nm);
        @(negedge clk1);
        id_valid = v; id_op = op; id_ind = ind; cond_zr = zr; cond_ng = ng;
        resume = res; rst = rs;
        @(posedge clk1);
        if (chk) sb.push_back('{v: e, nm: nm});
    endtask

    initial begin
        logic [29:0] rst_v, halt_v, stall_v;
        rst = 1'b1; id_valid = 0; id_op = '0; id_ind = 0; cond_zr = 0; cond_ng = 0;
        resume = 0;
        rst_v = ev(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 16'd0);

        cyc(0, 5'h00, 0, 0, 0, 0, 1, 1, rst_v, "reset");
        cyc(1, 5'h07, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 1, 1, 0, 6'b001111, 0, 0, 1), "alu07");
        cyc(0, 5'h07, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 0, 0, 0, 6'b0, 0, 0, 1), "bubble");
        cyc(1, 5'h02, 1, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 6'b0, 1, 0, 1), "ind_wait");
        cyc(1, 5'h13, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 1, 1, 0, 6'b111010, 0, 0, 2), "ind_issue");
        cyc(1, 5'h13, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 1, 0, 1, 6'b0, 0, 0, 3), "store");
        cyc(1, 5'h13, 0, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 3), "store_hold");
        cyc(1, 5'h13, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 1, 0, 1, 6'b0, 0, 0, 4), "store2");
        cyc(1, 5'h1A, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 1, 1, 0, 6'b101101, 0, 0, 5), "cb_dflt");
        cyc(1, 5'h15, 0, 1, 0, 0, 0, 1, ev(1, 1, 1, 0, 0, 0, 6'b0, 0, 0, 6), "jz_taken");
        stall_v = ev(0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 6);
        cyc(1, 5'h07, 0, 0, 0, 0, 0, 1, stall_v, "br_bub1");
        cyc(1, 5'h07, 0, 0, 0, 0, 0, 1, stall_v, "br_bub2");
        cyc(0, 5'h07, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 0, 0, 0, 6'b0, 0, 0, 6), "br_done");
        cyc(1, 5'h15, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 0, 0, 0, 6'b0, 0, 0, 7), "jz_not");
        cyc(1, 5'h16, 1, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 6'b0, 1, 0, 7), "jn_ind");
        cyc(0, 5'h00, 0, 0, 1, 0, 0, 1, ev(1, 1, 1, 0, 0, 0, 6'b0, 0, 0, 8), "jn_taken");
        stall_v = ev(0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 8);
        cyc(0, 5'h00, 0, 0, 0, 0, 0, 1, stall_v, "jn_bub1");
        cyc(0, 5'h00, 0, 0, 0, 0, 0, 1, stall_v, "jn_bub2");
        cyc(1, 5'h14, 0, 0, 0, 0, 0, 1, ev(1, 1, 1, 0, 0, 0, 6'b0, 0, 0, 9), "jmp");
        cyc(1, 5'h07, 0, 0, 0, 0, 1, 1, rst_v, "rst_in_branch");

        cyc(1, 5'h17, 1, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 6'b0, 0, 1, 1), "hlt");
        halt_v = ev(0, 0, 0, 0, 0, 0, 6'b0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 5'h07, i[0], 1, 1, 0, 0, 1, halt_v, "halt_hold");
        end
        cyc(1, 5'h07, 0, 0, 0, 1, 0, 1, ev(1, 0, 0, 0, 0, 0, 6'b0, 0, 0, 1), "resume");
        cyc(0, 5'h07, 0, 0, 0, 1, 0, 1, ev(1, 0, 0, 0, 0, 0, 6'b0, 0, 0, 1), "resume_ign");
        cyc(1, 5'h03, 1, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 6'b0, 1, 0, 1), "ind2");
        cyc(1, 5'h07, 0, 0, 0, 0, 1, 1, rst_v, "rst_in_ind");
        cyc(0, 5'h07, 0, 0, 0, 0, 0, 1, rst_v, "ind_discard");

        for (int i = 0; i < 65534; i++) begin
            cyc(1, 5'h10, 0, 0, 0, 0, 0, 0, '0, "");
        end
        cyc(1, 5'h10, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 1, 1, 0, 6'b000000, 0, 0, 16'hFFFF),
            "ret_ffff");
        cyc(1, 5'h11, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 1, 1, 0, 6'b010101, 0, 0, 16'h0000),
            "ret_wrap");
        cyc(0, 5'h00, 0, 0, 0, 0, 0, 1, ev(1, 0, 0, 0, 0, 0, 6'b0, 0, 0, 16'h0000),
            "post_wrap");

        repeat (3) @(posedge clk1);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
